// File: rtl/tlc_pkg.sv
// Shared types and constants for the two-road phase scheduler: phase encoding,
// default durations and the phase-to-lamp decode.
package tlc_pkg;

  typedef enum logic [2:0] {
    PH_G1 = 3'd0,
    PH_Y1 = 3'd1,
    PH_R1 = 3'd2,
    PH_G2 = 3'd3,
    PH_Y2 = 3'd4,
    PH_R2 = 3'd5
  } phase_t;

  localparam int unsigned T_GRN_MIN_DEF = 8;
  localparam int unsigned T_GRN_MAX_DEF = 32;
  localparam int unsigned T_YLW_DEF     = 4;
  localparam int unsigned T_ALLRED_DEF  = 2;
  localparam int unsigned T_WALK_DEF    = 6;
  localparam int unsigned PRESCALE_DEF  = 16;

  typedef struct packed {
    logic grn1;
    logic ylw1;
    logic red1;
    logic grn2;
    logic ylw2;
    logic red2;
  } lamps_t;

  // Exactly one lamp per road is lit in every phase.
  function automatic lamps_t lamp_decode(phase_t ph);
    lamps_t l;
    l = '0;
    case (ph)
      PH_G1:        begin l.grn1 = 1'b1; l.red2 = 1'b1; end
      PH_Y1:        begin l.ylw1 = 1'b1; l.red2 = 1'b1; end
      PH_G2:        begin l.red1 = 1'b1; l.grn2 = 1'b1; end
      PH_Y2:        begin l.red1 = 1'b1; l.ylw2 = 1'b1; end
      default:      begin l.red1 = 1'b1; l.red2 = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_sched_if.sv
// Sensor inputs and lamp outputs of the phase scheduler, grouped as one bundle.
interface tlc_phase_sched_if;
  logic       FM;
  logic       PED;
  logic       TEST;
  logic       GRN1;
  logic       YLW1;
  logic       RED1;
  logic       GRN2;
  logic       YLW2;
  logic       RED2;
  logic       WALK;
  logic [2:0] PHASE;

  modport master (
    output FM, PED, TEST,
    input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK, PHASE
  );

  modport slave (
    input  FM, PED, TEST,
    output GRN1, YLW1, RED1, GRN2, YLW2, RED2, WALK, PHASE
  );
endinterface

// File: rtl/tlc_tick_gen.sv
// Duration tick source: free-running prescaler, overridden to one tick per
// clock (prescaler parked at 0) while test mode is selected.
module tlc_tick_gen #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic test_i,
  output logic tick_o
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] WRAP = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          wrap;

  assign wrap   = (presc_q == WRAP);
  assign tick_o = test_i | wrap;

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (test_i || wrap) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/tlc_phase_sched.sv
// Six-phase highway/farm-road scheduler: sensor synchronisers, pedestrian
// latch, per-phase duration timer and the phase FSM that drives the lamps.
module tlc_phase_sched
  import tlc_pkg::*;
#(
  parameter int unsigned T_GRN_MIN = T_GRN_MIN_DEF,
  parameter int unsigned T_GRN_MAX = T_GRN_MAX_DEF,
  parameter int unsigned T_YLW     = T_YLW_DEF,
  parameter int unsigned T_ALLRED  = T_ALLRED_DEF,
  parameter int unsigned T_WALK    = T_WALK_DEF,
  parameter int unsigned PRESCALE  = PRESCALE_DEF
) (
  input  logic             clock,
  input  logic             CLR,
  tlc_phase_sched_if.slave io
);

  localparam int TW = $clog2(T_GRN_MAX);
  localparam logic [TW-1:0] LD_G1  = TW'(T_GRN_MIN - 1);
  localparam logic [TW-1:0] LD_YLW = TW'(T_YLW - 1);
  localparam logic [TW-1:0] LD_AR  = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] LD_G2  = TW'(T_GRN_MAX - 1);
  // G2 timer values at which min-green is satisfied / the walk interval ends,
  // counting the current tick as elapsed.
  localparam logic [TW-1:0] MIN_PT   = TW'(T_GRN_MAX - T_GRN_MIN);
  localparam logic [TW-1:0] WALK_END = TW'(T_GRN_MAX - T_WALK);

  phase_t        phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic          walk_q, walk_d;
  logic          fm_s1_q, fm_s2_q, ped_s1_q, ped_s2_q;
  logic          tick, farm_req, ped_s, tmr_zero;
  lamps_t        lamps;

  tlc_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clock),
    .rst    (CLR),
    .test_i (io.TEST),
    .tick_o (tick)
  );

  assign farm_req = fm_s2_q;
  assign ped_s    = ped_s2_q;
  assign tmr_zero = (timer_q == '0);

  always_comb begin
    phase_d    = phase_q;
    timer_d    = timer_q;
    ped_pend_d = ped_pend_q | ped_s;
    walk_d     = walk_q;
    if (tick) begin
      case (phase_q)
        PH_G1: begin
          if (!tmr_zero) timer_d = timer_q - 1'b1;
          else if (farm_req || ped_pend_q) begin
            phase_d = PH_Y1;
            timer_d = LD_YLW;
          end
        end
        PH_Y1: begin
          if (!tmr_zero) timer_d = timer_q - 1'b1;
          else begin
            phase_d = PH_R1;
            timer_d = LD_AR;
          end
        end
        PH_R1: begin
          if (!tmr_zero) timer_d = timer_q - 1'b1;
          else begin
            // A press arriving on the entry cycle is served by this G2.
            phase_d    = PH_G2;
            timer_d    = LD_G2;
            walk_d     = ped_pend_q | ped_s;
            ped_pend_d = 1'b0;
          end
        end
        PH_G2: begin
          if (tmr_zero || (!farm_req && (timer_q <= MIN_PT) && !walk_q)) begin
            phase_d = PH_Y2;
            timer_d = LD_YLW;
            walk_d  = 1'b0;
          end else begin
            timer_d = timer_q - 1'b1;
            if (timer_q == WALK_END) walk_d = 1'b0;
          end
        end
        PH_Y2: begin
          if (!tmr_zero) timer_d = timer_q - 1'b1;
          else begin
            phase_d = PH_R2;
            timer_d = LD_AR;
          end
        end
        PH_R2: begin
          if (!tmr_zero) timer_d = timer_q - 1'b1;
          else begin
            phase_d = PH_G1;
            timer_d = LD_G1;
          end
        end
        default: begin
          phase_d = PH_G1;
          timer_d = LD_G1;
          walk_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (CLR) begin
      phase_q    <= PH_G1;
      timer_q    <= LD_G1;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      fm_s1_q    <= 1'b0;
      fm_s2_q    <= 1'b0;
      ped_s1_q   <= 1'b0;
      ped_s2_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      fm_s1_q    <= io.FM;
      fm_s2_q    <= fm_s1_q;
      ped_s1_q   <= io.PED;
      ped_s2_q   <= ped_s1_q;
    end
  end

  assign lamps    = lamp_decode(phase_q);
  assign io.GRN1  = lamps.grn1;
  assign io.YLW1  = lamps.ylw1;
  assign io.RED1  = lamps.red1;
  assign io.GRN2  = lamps.grn2;
  assign io.YLW2  = lamps.ylw2;
  assign io.RED2  = lamps.red2;
  assign io.WALK  = walk_q;
  assign io.PHASE = phase_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed bench: expected phase runs (phase, length, WALK cycles) are queued
// with each stimulus and matched against runs recorded from the lamp outputs.
module tb_tlc_phase_sched;

  typedef struct {
    int ph;
    int len;
    int walk;
  } run_t;

  logic clock = 1'b0;
  logic CLR   = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  int   mon_ph, mon_len, mon_walk;
  run_t obs_q[$];
  run_t exp_q[$];

  tlc_phase_sched_if io ();

  tlc_phase_sched dut (
    .clock (clock),
    .CLR   (CLR),
    .io    (io)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] exp_lamps(int ph);
    case (ph)
      0:       return 6'b100_001;
      1:       return 6'b010_001;
      2, 5:    return 6'b001_001;
      3:       return 6'b001_100;
      4:       return 6'b001_010;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run recorder and per-cycle lamp decode check, sampled 1 time unit after the edge.
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      total++;
      assert ({io.GRN1, io.YLW1, io.RED1, io.GRN2, io.YLW2, io.RED2,
               io.WALK && (io.PHASE != 3'd3)} === {exp_lamps(int'(io.PHASE)), 1'b0}) else begin
        bad++;
        $error("FAIL lamps: phase=%0d observed=%b expected=%b", io.PHASE,
               {io.GRN1, io.YLW1, io.RED1, io.GRN2, io.YLW2, io.RED2, io.WALK},
               {exp_lamps(int'(io.PHASE)), 1'b0});
      end
      if (CLR || int'(io.PHASE) != mon_ph) begin
        if (!CLR) obs_q.push_back('{mon_ph, mon_len, mon_walk});
        mon_ph   = int'(io.PHASE);
        mon_len  = 1;
        mon_walk = int'(io.WALK);
      end else begin
        mon_len++;
        mon_walk += int'(io.WALK);
      end
    end
  end

  task automatic expect_run(int ph, int len, int walk);
    exp_q.push_back('{ph, len, walk});
  endtask

  task automatic do_reset(string tag);
    mon_en = 1'b1;
    CLR = 1'b1;
    @(negedge clock);
    chk({tag, "_rst_phase"}, int'(io.PHASE), 0);
    chk({tag, "_rst_grn1"}, int'(io.GRN1), 1);
    chk({tag, "_rst_red2"}, int'(io.RED2), 1);
    chk({tag, "_rst_others"}, int'({io.YLW1, io.RED1, io.GRN2, io.YLW2}), 0);
    chk({tag, "_rst_walk"}, int'(io.WALK), 0);
    CLR = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(string tag, int budget);
    int   n = 0;
    int   k = 0;
    run_t o, e;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_runs_seen"}, int'(obs_q.size() >= exp_q.size()), 1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("%s_r%0d_phase", tag, k), o.ph, e.ph);
      chk($sformatf("%s_r%0d_len", tag, k), o.len, e.len);
      chk($sformatf("%s_r%0d_walk", tag, k), o.walk, e.walk);
      k++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_for(string tag, int ph, int len, int budget);
    int n = 0;
    while (!(mon_ph == ph && mon_len == len) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_reached"}, int'(mon_ph == ph && mon_len == len), 1);
  endtask

  initial begin
    io.FM = 1'b0; io.PED = 1'b0; io.TEST = 1'b1;
    repeat (2) @(negedge clock);

    // S1: idle test mode, highway green holds forever.
    do_reset("s1");
    repeat (200) @(negedge clock);
    chk("s1_no_change", obs_q.size(), 0);
    chk("s1_phase", int'(io.PHASE), 0);
    chk("s1_len", mon_len, 201);

    // S2: farm car present throughout, farm green runs to maximum.
    do_reset("s2");
    io.FM = 1'b1;
    expect_run(0, 8, 0); expect_run(1, 4, 0); expect_run(2, 2, 0);
    expect_run(3, 32, 0); expect_run(4, 4, 0); expect_run(5, 2, 0);
    expect_run(0, 8, 0);
    drain("s2", 200);

    // S3: farm car leaves early, farm green ends at minimum.
    io.FM = 1'b0;
    do_reset("s3");
    io.FM = 1'b1;
    repeat (16) @(negedge clock);
    io.FM = 1'b0;
    expect_run(0, 8, 0); expect_run(1, 4, 0); expect_run(2, 2, 0);
    expect_run(3, 8, 0); expect_run(4, 4, 0); expect_run(5, 2, 0);
    drain("s3", 200);
    repeat (30) @(negedge clock);
    chk("s3_hold_g1", obs_q.size(), 0);
    chk("s3_hold_phase", int'(io.PHASE), 0);

    // S4: pedestrian press only: WALK for the first 6 ticks, then G1 holds.
    do_reset("s4");
    io.PED = 1'b1;
    repeat (3) @(negedge clock);
    io.PED = 1'b0;
    expect_run(0, 8, 0); expect_run(1, 4, 0); expect_run(2, 2, 0);
    expect_run(3, 8, 6); expect_run(4, 4, 0); expect_run(5, 2, 0);
    drain("s4", 200);
    repeat (30) @(negedge clock);
    chk("s4_ped_cleared", obs_q.size(), 0);
    chk("s4_hold_phase", int'(io.PHASE), 0);

    // S5a: normal mode, 16 clocks per tick.
    io.TEST = 1'b0;
    do_reset("s5a");
    io.FM = 1'b1;
    expect_run(0, 128, 0); expect_run(1, 64, 0); expect_run(2, 32, 0);
    drain("s5a", 600);

    // S5b: switch to test mode 20 cycles into Y1; one normal tick was used.
    io.FM = 1'b0;
    io.TEST = 1'b0;
    do_reset("s5b");
    io.FM = 1'b1;
    wait_for("s5b_y1", 1, 20, 400);
    io.TEST = 1'b1;
    expect_run(0, 128, 0); expect_run(1, 22, 0); expect_run(2, 2, 0);
    expect_run(3, 32, 0);
    drain("s5b", 400);

    // S6a: clear mid-Y2 aborts straight to G1, which then runs a fresh 8 ticks.
    io.FM = 1'b0;
    do_reset("s6a_pre");
    io.FM = 1'b1;
    wait_for("s6a_y2", 4, 2, 200);
    do_reset("s6a");
    expect_run(0, 8, 0);
    drain("s6a", 100);

    // S6b: press during WALK sets a pending request; clear must discard it.
    io.FM = 1'b0;
    do_reset("s6b_pre");
    io.PED = 1'b1;
    repeat (3) @(negedge clock);
    io.PED = 1'b0;
    wait_for("s6b_g2", 3, 1, 200);
    chk("s6b_walk_on", int'(io.WALK), 1);
    io.PED = 1'b1;
    repeat (2) @(negedge clock);
    io.PED = 1'b0;
    repeat (2) @(negedge clock);
    chk("s6b_walk_before_clr", int'(io.WALK), 1);
    do_reset("s6b");
    repeat (40) @(negedge clock);
    chk("s6b_ped_cleared", obs_q.size(), 0);
    chk("s6b_hold_phase", int'(io.PHASE), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
